// File: rtl/lc3_uarch_pkg.sv
// Shared LC-3 micro-architecture definitions: microinstruction field positions,
// COND encodings, the fetch microstate and the microsequencer FSM states.
package lc3_uarch_pkg;

  localparam int IRD_BIT    = 51;
  localparam int COND_MSB   = 50;
  localparam int COND_LSB   = 48;
  localparam int J_MSB      = 47;
  localparam int J_LSB      = 42;
  localparam int J_W        = J_MSB - J_LSB + 1;
  localparam int LD_BEN_BIT = 35;

  localparam logic [2:0] COND_NONE      = 3'b000;
  localparam logic [2:0] COND_MEM_READY = 3'b001;
  localparam logic [2:0] COND_BEN       = 3'b010;
  localparam logic [2:0] COND_ADDR_MODE = 3'b011;
  localparam logic [2:0] COND_PSR       = 3'b100;
  localparam logic [2:0] COND_INT       = 3'b101;

  localparam int FETCH_UADDR = 18;

  typedef enum logic [1:0] {
    USEQ_IDLE  = 2'd0,
    USEQ_PRIME = 2'd1,
    USEQ_RUN   = 2'd2
  } useq_state_t;

endpackage

// File: rtl/lc3_ben_logic.sv
// Combinational branch-enable expression, shared with the datapath checker.
module lc3_ben_logic (
  input  logic [2:0] ir_nzp,
  input  logic       n,
  input  logic       z,
  input  logic       p,
  output logic       ben
);

  assign ben = (ir_nzp[2] & n) | (ir_nzp[1] & z) | (ir_nzp[0] & p);

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 next-microaddress generator feeding a registered-read control store.
// Define LC3_USEQ_INT_EN to make COND=101 branch on the interrupt input.
module lc3_microsequencer
  import lc3_uarch_pkg::*;
#(
  parameter int UADDR_W     = 6,
  parameter int UINST_W     = 52,
  parameter int FETCH_UADDR = lc3_uarch_pkg::FETCH_UADDR
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic [UINST_W-1:0] i_uinst,
  input  logic [15:0]        i_ir,
  input  logic               i_n,
  input  logic               i_z,
  input  logic               i_p,
  input  logic               i_mem_ready,
  input  logic               i_psr15,
  input  logic               i_int,
  input  logic               i_stall,
  output logic               o_read_en,
  output logic [UADDR_W-1:0] o_read_addr,
  output logic [UADDR_W-1:0] o_uaddr,
  output logic               o_ben,
  output logic               o_advance
);

  useq_state_t        state_reg, state_next;
  logic [UADDR_W-1:0] uaddr_reg;
  logic               ben_reg, ben_next, ben_calc;
  logic [2:0]         cond;
  logic [J_W-1:0]     j_field, j_mod;
  logic [UADDR_W-1:0] next_uaddr;
  logic               unused_bits;

  assign cond    = i_uinst[COND_MSB:COND_LSB];
  assign j_field = i_uinst[J_MSB:J_LSB];

  lc3_ben_logic u_ben_logic (
    .ir_nzp (i_ir[11:9]),
    .n      (i_n),
    .z      (i_z),
    .p      (i_p),
    .ben    (ben_calc)
  );

  // Branch modifiers OR a single status bit into J; BEN is always the registered copy.
  always_comb begin
    j_mod = '0;
    case (cond)
      COND_MEM_READY: j_mod[1] = i_mem_ready;
      COND_BEN:       j_mod[2] = ben_reg;
      COND_ADDR_MODE: j_mod[0] = i_ir[11];
      COND_PSR:       j_mod[3] = i_psr15;
`ifdef LC3_USEQ_INT_EN
      COND_INT:       j_mod[4] = i_int;
`else
      COND_INT:       j_mod    = '0;
`endif
      default:        j_mod    = '0;
    endcase
  end

  assign next_uaddr = i_uinst[IRD_BIT] ? UADDR_W'(i_ir[15:12])
                                       : UADDR_W'(j_field | j_mod);

  always_comb begin
    state_next  = state_reg;
    o_read_en   = 1'b0;
    o_read_addr = UADDR_W'(FETCH_UADDR);
    o_advance   = 1'b0;
    case (state_reg)
      USEQ_IDLE: state_next = USEQ_PRIME;
      USEQ_PRIME: begin
        state_next = USEQ_RUN;
        o_read_en  = 1'b1;
      end
      USEQ_RUN: begin
        o_read_en = 1'b1;
        // A stall re-reads the current word so the control store output stays put.
        if (i_stall) begin
          o_read_addr = uaddr_reg;
        end else begin
          o_read_addr = next_uaddr;
          o_advance   = 1'b1;
        end
      end
      default: state_next = USEQ_IDLE;
    endcase
  end

  assign ben_next = (o_advance && i_uinst[LD_BEN_BIT]) ? ben_calc : ben_reg;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_reg <= USEQ_IDLE;
      uaddr_reg <= '0;
      ben_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (o_read_en) uaddr_reg <= o_read_addr;
      ben_reg   <= ben_next;
    end
  end

  assign o_uaddr = uaddr_reg;
  assign o_ben   = ben_reg;

  // Datapath-only microinstruction bits and the remaining IR bits are not needed here.
  assign unused_bits = ^{i_uinst, i_ir, i_int};

endmodule

// File: doc/lc3_microsequencer.md
# lc3_microsequencer

Next-microaddress generator for the LC-3 microcoded control unit. Sits directly upstream of the 64 x 52-bit control store. It consumes the microinstruction the control store currently presents, together with IR, condition codes and status inputs, and drives the control store's read enable and read address. It owns the BEN register, a reset/priming state machine, and stall handling that keeps the registered control-store output stable.

## Interface
- `UADDR_W`, default 6: microaddress width.
- `UINST_W`, default 52: microinstruction width.
- `FETCH_UADDR`, default 18: first microstate after reset.
- `i_CLK`  in  1  clock.
- `i_RST_N`  in  1  reset. One clock; reset is asynchronous, active-low.
- `i_uinst`  in  UINST_W  current microinstruction, taken from the control store read data.
- `i_ir`  in  16  instruction register.
- `i_n`, `i_z`, `i_p`  in  1 each  condition codes.
- `i_mem_ready`  in  1  memory ready (R).
- `i_psr15`  in  1  PSR[15], privilege bit.
- `i_int`  in  1  interrupt pending.
- `i_stall`  in  1  hold current microstate.
- `o_read_en`  out  1  control store read enable.
- `o_read_addr`  out  UADDR_W  control store read address.
- `o_uaddr`  out  UADDR_W  address of the microinstruction now on `i_uinst`.
- `o_ben`  out  1  BEN register.
- `o_advance`  out  1  high when `i_uinst` is valid and is being consumed this cycle.

## Operation
- Microinstruction fields:
  - [51] IRD
  - [50:48] COND
  - [47:42] J
  - [35] LD.BEN
  - all other bits are datapath controls and are ignored here.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: entered on reset. Next state is PRIME.
  - PRIME: issues read of `FETCH_UADDR`. Next state is RUN.
  - RUN: stays in RUN.
- Next address in RUN when `i_stall`=0:
  - If IRD=1: next = {2'b00, `i_ir`[15:12]}.
  - Otherwise: next = J OR mod, where mod depends on COND:
    - 000: mod = 0
    - 001: J[1] |= `i_mem_ready`
    - 010: J[2] |= BEN
    - 011: J[0] |= `i_ir`[11]
    - 100: J[3] |= `i_psr15`
    - 101: J[4] |= `i_int` (see Configuration)
    - 110, 111: treated as 000
- Output drive by state:
  - RUN, `i_stall`=0: `o_read_en`=1, `o_read_addr`=next (combinational), `o_advance`=1.
  - RUN, `i_stall`=1: `o_read_en`=1, `o_read_addr`=`o_uaddr` (re-read of the same word, so the control store output is unchanged). `o_advance`=0. BEN and `o_uaddr` hold.
  - PRIME: `o_read_en`=1, `o_read_addr`=`FETCH_UADDR`, `o_advance`=0.
  - IDLE: `o_read_en`=0, `o_read_addr`=`FETCH_UADDR`, `o_advance`=0.
- `o_uaddr` register:
  - Loads `o_read_addr` on every edge where `o_read_en`=1.
  - This keeps `o_uaddr` aligned with the control store's registered output.
- BEN: on an edge where `o_advance`=1 and LD.BEN=1, BEN <= (`i_ir`[11]&`i_n`) | (`i_ir`[10]&`i_z`) | (`i_ir`[9]&`i_p`). Next-address logic always uses the registered BEN value, not the value being computed.
- Reset values (asynchronous): state=IDLE, `o_uaddr`=0, BEN=0, `o_read_en`=0, `o_advance`=0, `o_read_addr`=`FETCH_UADDR`.
- Reset asserted mid-operation: all of the above are forced immediately. Any in-flight microstate is abandoned.
- `i_stall` outside RUN is ignored.

## Timing
- First edge after reset release: IDLE -> PRIME.
- Second edge: the control store latches word 18. The FSM enters RUN with `o_uaddr`=18 and `o_advance`=1.
- The first valid microinstruction is therefore consumed 2 cycles after reset release.
- In RUN, one microstate per cycle. The address presented in cycle t is the microinstruction seen in cycle t+1.
- Next address is purely combinational from `i_uinst` and the inputs; there is no extra register stage.
- A stall of N cycles adds exactly N cycles. The address sequence resumes unchanged.

## Configuration
- `LC3_USEQ_INT_EN` defined: COND=101 ORs `i_int` into J[4].
- Undefined: COND=101 behaves as unconditional (mod=0). `i_int` remains a port but is ignored.

## Structure
- Shared package `lc3_uarch_pkg`:
  - field bit-position constants (IRD, COND, J, LD.BEN)
  - COND encoding constants
  - `FETCH_UADDR`
  - FSM state typedef
- Optional sub-module `lc3_ben_logic`: the combinational BEN expression. It is reused by the datapath checker.

## Test plan
- Reset release -> `o_read_en` 0 then 1 with `o_read_addr`=18. RUN is reached on the 2nd edge with `o_uaddr`=18.
- IRD=1, `i_ir`=16'h1234 -> `o_read_addr`=1.
- COND=001, J=33:
  - `i_mem_ready`=0 -> 33.
  - `i_mem_ready`=1 -> 35.
- LD.BEN=1 with `i_ir`[11:9]=3'b010, `i_z`=1 -> BEN=1. Next cycle COND=010, J=18 -> 22. With BEN=0 -> 18.
- COND=101, J=33, `i_int`=1 -> 49 with `LC3_USEQ_INT_EN` defined, 33 without it. COND=011, J=20, `i_ir`[11]=1 -> 21.
- `i_stall`=1 for 3 cycles at `o_uaddr`=35 -> `o_read_addr`=35 and `o_advance`=0 for 3 cycles, BEN unchanged, then the sequence resumes. Reset pulse mid-run -> outputs return to reset values immediately.
